// File: rtl/irq_ctrl_pkg.sv
// Shared types, constants and helpers for the interrupt controller.
package irq_ctrl_pkg;

  // Upper bound on the number of request lines.
  localparam int IRQ_CTRL_MAX_N = 32;
  // Width of an index into a vector of IRQ_CTRL_MAX_N bits.
  localparam int PRIO_IDX_W = 5;

  // Presentation state machine.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } irq_state_e;

  // Result of a priority search.
  typedef struct packed {
    logic                  found;
    logic [PRIO_IDX_W-1:0] idx;
  } prio_t;

  // Returns the lowest set bit of vec and whether any bit was set.
  function automatic prio_t prio_sel(input logic [IRQ_CTRL_MAX_N-1:0] vec);
    prio_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = IRQ_CTRL_MAX_N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.found = 1'b1;
        r.idx   = PRIO_IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_edge_det.sv
// Per-line request capture: optional input synchroniser, previous-sample
// flop, edge/level pending bit and sticky overrun flag.
// Optional feature macro: IRQ_CTRL_SYNC_EN (2-flop synchroniser on the input).
module irq_edge_det
  import irq_ctrl_pkg::*;
(
  input  logic clk,
  input  logic srst,
  input  logic ireq,
  input  logic edge_sel,
  input  logic ack_hit,
  output logic pending,
  output logic overrun
);

  logic samp;
  logic prev_reg;
  logic pending_reg;
  logic overrun_reg;
  logic rise;

`ifdef IRQ_CTRL_SYNC_EN
  logic sync_q1_reg;
  logic sync_q2_reg;

  // Two-stage synchroniser for an asynchronous request line.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync_q1_reg <= 1'b0;
      sync_q2_reg <= 1'b0;
    end else begin
      sync_q1_reg <= ireq;
      sync_q2_reg <= sync_q1_reg;
    end
  end

  assign samp = sync_q2_reg;
`else
  assign samp = ireq;
`endif

  // Previous sample resets to 0 so a line high at reset release is an edge.
  assign rise = samp & ~prev_reg;

  // Pending/overrun update: on a coincident edge and ack the edge wins for
  // pending while the ack still clears overrun.
  always_ff @(posedge clk) begin
    if (srst) begin
      prev_reg    <= 1'b0;
      pending_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      prev_reg <= samp;
      if (edge_sel) begin
        pending_reg <= rise | (pending_reg & ~ack_hit);
        overrun_reg <= ack_hit ? 1'b0 : (overrun_reg | (rise & pending_reg));
      end else begin
        pending_reg <= samp;
        overrun_reg <= overrun_reg & ~ack_hit;
      end
    end
  end

  assign pending = pending_reg;
  assign overrun = overrun_reg;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller top: per-line capture, fixed-priority selection and
// the IDLE/ACTIVE/GAP presentation FSM with registered outputs.
// Optional feature macro: IRQ_CTRL_SYNC_EN (input synchronisers in irq_edge_det).
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_IREQ = 5,
  parameter int ID_W   = (N_IREQ > 1) ? $clog2(N_IREQ) : 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [N_IREQ-1:0] IREQ,
  input  logic [N_IREQ-1:0] edge_sel,
  input  logic [N_IREQ-1:0] mask,
  input  logic              ack,
  output logic              IRQ,
  output logic [ID_W-1:0]   irq_id,
  output logic [N_IREQ-1:0] pending,
  output logic [N_IREQ-1:0] overrun
);

  irq_state_e state_reg;
  irq_state_e state_next;
  logic              irq_reg;
  logic              irq_next;
  logic [ID_W-1:0]   irq_id_reg;
  logic [ID_W-1:0]   irq_id_next;
  logic [N_IREQ-1:0] pending_w;
  logic [N_IREQ-1:0] overrun_w;
  logic [N_IREQ-1:0] ack_hit;
  logic [IRQ_CTRL_MAX_N-1:0] req_vec;
  prio_t             sel;

  // One capture cell per request line; an ack only hits the presented line.
  generate
    for (genvar gi = 0; gi < N_IREQ; gi++) begin : g_line
      assign ack_hit[gi] = (state_reg == ACTIVE) && ack && (irq_id_reg == ID_W'(gi));

      irq_edge_det u_edge_det (
        .clk      (PCLK),
        .srst     (PRESET),
        .ireq     (IREQ[gi]),
        .edge_sel (edge_sel[gi]),
        .ack_hit  (ack_hit[gi]),
        .pending  (pending_w[gi]),
        .overrun  (overrun_w[gi])
      );
    end
  endgenerate

  // Mask gates only selection, never latching.
  assign req_vec = IRQ_CTRL_MAX_N'(pending_w & mask);
  assign sel     = prio_sel(req_vec);

  // Next-state and next-output logic; ID is frozen outside IDLE.
  always_comb begin
    state_next  = state_reg;
    irq_id_next = irq_id_reg;
    case (state_reg)
      IDLE: begin
        if (sel.found) begin
          state_next  = ACTIVE;
          irq_id_next = sel.idx[ID_W-1:0];
        end
      end
      ACTIVE: begin
        if (ack) begin
          state_next = GAP;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    irq_next = (state_next == ACTIVE);
  end

  // State and output registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_reg  <= IDLE;
      irq_reg    <= 1'b0;
      irq_id_reg <= '0;
    end else begin
      state_reg  <= state_next;
      irq_reg    <= irq_next;
      irq_id_reg <= irq_id_next;
    end
  end

  assign IRQ     = irq_reg;
  assign irq_id  = irq_id_reg;
  assign pending = pending_w;
  assign overrun = overrun_w;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (default build, N_IREQ = 5).
module tb_irq_ctrl;

  localparam int N    = 5;
  localparam int ID_W = 3;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic [N-1:0]  IREQ;
  logic [N-1:0]  edge_sel;
  logic [N-1:0]  mask;
  logic          ack;
  logic          IRQ;
  logic [ID_W-1:0] irq_id;
  logic [N-1:0]  pending;
  logic [N-1:0]  overrun;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl #(.N_IREQ(N)) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .IREQ     (IREQ),
    .edge_sel (edge_sel),
    .mask     (mask),
    .ack      (ack),
    .IRQ      (IRQ),
    .irq_id   (irq_id),
    .pending  (pending),
    .overrun  (overrun)
  );

  always #5 PCLK = ~PCLK;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_irq(input string tag, input logic exp_irq, input logic [ID_W-1:0] exp_id);
    chk({tag, "_irq"}, 32'(IRQ), 32'(exp_irq));
    if (exp_irq) chk({tag, "_id"}, 32'(irq_id), 32'(exp_id));
    $display("step %s: IRQ=%0b irq_id=%0d pending=%b overrun=%b", tag, IRQ, irq_id, pending, overrun);
  endtask

  initial begin
    PRESET   = 1'b1;
    IREQ     = '0;
    edge_sel = 5'b11111;
    mask     = 5'b11111;
    ack      = 1'b0;

    // Reset state
    step(); step();
    chk("rst_irq", 32'(IRQ), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    PRESET = 1'b0;
    step();

    // Edge basic: pulse line 3
    IREQ = 5'b01000; step();
    chk("e_pend", 32'(pending), 32'b01000);
    chk_irq("e_lat1", 1'b0, 3'd0);
    IREQ = 5'b00000; step();
    chk_irq("e_lat2", 1'b1, 3'd3);
    ack = 1'b1; step(); ack = 1'b0;
    chk_irq("e_ack", 1'b0, 3'd0);
    chk("e_ack_pend", 32'(pending), 32'd0);
    step(); step();
    chk_irq("e_quiet", 1'b0, 3'd0);

    // Priority and freeze
    IREQ = 5'b10000; step();
    IREQ = 5'b00000; step();
    chk_irq("p_act4", 1'b1, 3'd4);
    IREQ = 5'b00010; step();
    chk("p_pend", 32'(pending), 32'b10010);
    chk_irq("p_frz1", 1'b1, 3'd4);
    IREQ = 5'b00000; step();
    chk_irq("p_frz2", 1'b1, 3'd4);
    ack = 1'b1; step(); ack = 1'b0;
    chk_irq("p_gap", 1'b0, 3'd0);
    chk("p_pend2", 32'(pending), 32'b00010);
    step();
    chk_irq("p_idle", 1'b0, 3'd0);
    step();
    chk_irq("p_act1", 1'b1, 3'd1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("p_clr", 32'(pending), 32'd0);
    step(); step();

    // Stray ack in IDLE is ignored
    ack = 1'b1; step(); ack = 1'b0;
    chk_irq("stray", 1'b0, 3'd0);

    // Overrun: two edges on line 2, three cycles apart
    IREQ = 5'b00100; step();
    chk("o_pend", 32'(pending), 32'b00100);
    IREQ = 5'b00000; step();
    chk_irq("o_act", 1'b1, 3'd2);
    chk("o_none", 32'(overrun), 32'd0);
    step();
    IREQ = 5'b00100; step();
    chk("o_set", 32'(overrun), 32'b00100);
    IREQ = 5'b00000;
    ack = 1'b1; step(); ack = 1'b0;
    chk("o_clr_ovr", 32'(overrun), 32'd0);
    chk("o_clr_pend", 32'(pending), 32'd0);
    chk_irq("o_gap", 1'b0, 3'd0);
    step(); step();

    // Simultaneous ack and new edge on line 0
    IREQ = 5'b00001; step();
    IREQ = 5'b00000; step();
    chk_irq("s_act", 1'b1, 3'd0);
    step();
    IREQ = 5'b00001; ack = 1'b1; step(); ack = 1'b0; IREQ = 5'b00000;
    chk("s_pend", 32'(pending), 32'b00001);
    chk("s_ovr", 32'(overrun), 32'd0);
    chk_irq("s_gap", 1'b0, 3'd0);
    step();
    chk_irq("s_idle", 1'b0, 3'd0);
    step();
    chk_irq("s_react", 1'b1, 3'd0);
    ack = 1'b1; step(); ack = 1'b0;
    chk("s_clr", 32'(pending), 32'd0);
    step(); step();

    // Level line with mask
    edge_sel = 5'b11110; mask = 5'b11110;
    IREQ = 5'b00001; step();
    chk("l_pend", 32'(pending), 32'b00001);
    step();
    chk_irq("l_masked", 1'b0, 3'd0);
    mask = 5'b11111; step();
    chk_irq("l_act", 1'b1, 3'd0);
    ack = 1'b1; step(); ack = 1'b0;
    chk_irq("l_gap", 1'b0, 3'd0);
    chk("l_pend_hold", 32'(pending), 32'b00001);
    step();
    step();
    chk_irq("l_react", 1'b1, 3'd0);
    IREQ = 5'b00000; step();
    chk("l_pend_drop", 32'(pending), 32'd0);
    chk_irq("l_nowithdraw", 1'b1, 3'd0);
    ack = 1'b1; step(); ack = 1'b0;
    step(); step();
    chk_irq("l_quiet", 1'b0, 3'd0);

    // Reset mid-ACTIVE with line 1 held high through release
    edge_sel = 5'b11111;
    IREQ = 5'b00010; step();
    step();
    chk_irq("r_act", 1'b1, 3'd1);
    PRESET = 1'b1; step();
    chk("r_irq", 32'(IRQ), 32'd0);
    chk("r_id", 32'(irq_id), 32'd0);
    chk("r_pend", 32'(pending), 32'd0);
    chk("r_ovr", 32'(overrun), 32'd0);
    PRESET = 1'b0; step();
    chk("r_edge", 32'(pending), 32'b00010);
    step();
    chk_irq("r_act2", 1'b1, 3'd1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("r_clr", 32'(pending), 32'd0);
    step(); step();
    chk_irq("r_single", 1'b0, 3'd0);
    chk("r_single_pend", 32'(pending), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
